ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
Sequencer between the processor core and the 4096x4 asynchronous RAM. It turns a single-cycle request into a glitch-free burst of 1..16 nibble reads or writes, and drives the RAM's address, chip-select, write-enable and shared bidirectional data bus. Per-beat timing is SETUP/STROBE/HOLD, so address and data are stable whenever the RAM is selected. The core receives read nibbles on a valid strobe and supplies write nibbles on request.

Parameters:
ADDR_W, 12, RAM address width; wraps modulo 2^ADDR_W.
DATA_W, 4, RAM data width.
LEN_W, 4, burst length field width; burst = len+1 beats (1..16).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req  in  1  start request; sampled only in IDLE.
wr  in  1  1 = write burst, 0 = read burst; sampled with req.
addr  in  ADDR_W  start address; sampled with req.
len  in  LEN_W  beats minus one; sampled with req.
wdata  in  DATA_W  write nibble; sampled on the edge ending a cycle with wdata_req=1.
wdata_req  out  1  one-cycle pulse in each write-beat SETUP.
rdata  out  DATA_W  last nibble read; holds its value between beats.
rvalid  out  1  one-cycle pulse in the HOLD of each read beat; rdata valid.
busy  out  1  high from the cycle after acceptance through the final HOLD.
done  out  1  one-cycle pulse in the first IDLE cycle after the final HOLD.
address_ram  out  ADDR_W  RAM address, registered.
csRAM  out  1  RAM chip select, registered.
weRAM  out  1  RAM write enable, registered.
data  inout  DATA_W  shared RAM data bus.

Behaviour:
- Reset (async, immediate): state=IDLE; csRAM=0, weRAM=0, address_ram=0, rdata=0, rvalid=0, wdata_req=0, busy=0, done=0; data released to Z in the same instant.
- States: IDLE, SETUP, STROBE, HOLD. Each beat is 3 cycles; an N-beat burst takes 3N cycles and done pulses at cycle 3N+1 after the accepting edge.
- IDLE: csRAM=0, weRAM=0, data=Z. On req=1, latch wr/addr/len, set beat counter=len, go to SETUP. done is never high in the same cycle as a new acceptance that is visible as busy.
- SETUP: address_ram=current address, csRAM=0, weRAM=latched wr. For writes, wdata_req=1 and wdata is captured into an internal register at the end of the cycle. Next state: STROBE.
- STROBE: csRAM=1, weRAM=wr, address unchanged.
  - Write: data driven with the captured nibble.
  - Read: data=Z; data is sampled into rdata at the end of the cycle.
  - Next state: HOLD.
- HOLD: csRAM=0, address and weRAM unchanged; on writes, data is still driven. Read: rvalid=1.
  - If beat counter=0: go to IDLE and pulse done.
  - Otherwise: decrement the counter, increment the address modulo 2^ADDR_W (0xFFF -> 0x000), go to SETUP.
- Bus rule: the controller drives data only in write-burst STROBE or HOLD. It never drives data while csRAM=1 and weRAM=0. No bus contention in any state.
- Glitch rule: address_ram and weRAM change only in SETUP, or on entry to IDLE/SETUP while csRAM=0. csRAM is never high across an address change.
- req while busy: ignored, with no effect on the burst in flight; the core must re-assert it after done.
- req held high continuously: a new burst is accepted on the first IDLE cycle, i.e. the done cycle.
- len=0: single beat, 3 cycles.
- Reset mid-burst: abort immediately, with no further RAM strobe and no done pulse. Any write already strobed stays written.

Test Plan:
1. Single write: req, wr=1, addr=0x123, len=0, wdata=0xA -> csRAM high exactly 1 cycle with address_ram=0x123, weRAM=1, data=0xA; done at cycle 4; busy cycles 1-3.
2. Single read back: req, wr=0, addr=0x123, len=0 -> data Z from the controller throughout, rvalid at cycle 3 with rdata=0xA, done at cycle 4.
3. Wrapping burst write then read: addr=0xFFE, len=3, wdata 1,2,3,4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001. Read-back burst gives 4 rvalid pulses with rdata 1,2,3,4, spaced 3 cycles apart; done at cycle 13.
4. req during busy: new req (wr=1, addr=0x000) pulsed mid-burst of test 3's read -> ignored; RAM 0x000 still 3; no extra strobe.
5. Reset mid-burst: assert reset during STROBE of beat 2 of a 4-beat write -> csRAM, weRAM and busy drop at once, data goes to Z, no done; only beat 1 is written.
6. Contention monitor over all tests: never (controller driving data && csRAM && !weRAM); address_ram stable whenever csRAM=1.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Burst sequencer for a 4096x4 asynchronous RAM: turns one core request into
// 1..16 SETUP/STROBE/HOLD nibble beats on a shared bidirectional data bus.
module ram_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address_ram,
    output logic              csRAM,
    output logic              weRAM,
    inout  wire  [DATA_W-1:0] data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              wreq_q, wreq_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              drv_q, drv_d;

    // Every RAM-facing output is computed for the next state and registered,
    // so address/we only move while cs is low and cs never glitches.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wbuf_d   = wbuf_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wreq_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cs_d     = cs_q;
        we_d     = we_q;
        drv_d    = drv_q;
        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b0;
                we_d   = 1'b0;
                drv_d  = 1'b0;
                busy_d = 1'b0;
                if (req) begin
                    state_d = S_SETUP;
                    wr_d    = wr;
                    addr_d  = addr;
                    cnt_d   = len;
                    busy_d  = 1'b1;
                    we_d    = wr;
                    wreq_d  = wr;
                end
            end
            S_SETUP: begin
                if (wr_q) wbuf_d = wdata;
                cs_d    = 1'b1;
                drv_d   = wr_q;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (!wr_q) begin
                    rdata_d  = data;
                    rvalid_d = 1'b1;
                end
                cs_d    = 1'b0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                drv_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    we_d    = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    wreq_d  = wr_q;
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wbuf_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wreq_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            drv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wbuf_q   <= wbuf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wreq_q   <= wreq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            drv_q    <= drv_d;
        end
    end

    assign data        = drv_q ? wbuf_q : {DATA_W{1'bz}};
    assign address_ram = addr_q;
    assign csRAM       = cs_q;
    assign weRAM       = we_q;
    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign wdata_req   = wreq_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 4096x4 RAM on the bus;
// every beat of every burst is checked cycle by cycle.
module tb_ram_access_ctrl;

    logic        clock;
    logic        reset;
    logic        req;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  len;
    logic [3:0]  wdata;
    logic        wdata_req;
    logic [3:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic        done;
    logic [11:0] address_ram;
    logic        csRAM;
    logic        weRAM;
    wire  [3:0]  data;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] mem [4096];
    logic [3:0] beat_v [16];

    ram_access_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .wr          (wr),
        .addr        (addr),
        .len         (len),
        .wdata       (wdata),
        .wdata_req   (wdata_req),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .busy        (busy),
        .done        (done),
        .address_ram (address_ram),
        .csRAM       (csRAM),
        .weRAM       (weRAM),
        .data        (data)
    );

    // clock / RAM model
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign data = (csRAM && !weRAM) ? mem[address_ram] : 4'bzzzz;

    always @(posedge clock) begin
        if (csRAM && weRAM) mem[address_ram] <= data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one burst from request to done, checking every cycle; a nonzero
    // inject_cyc pulses an extra write request during that burst cycle.
    task automatic run_burst(input logic w, input logic [11:0] a, input logic [3:0] l,
                             input int inject_cyc);
        int n;
        int b;
        int p;
        logic [11:0] ea;
        n = int'(l) + 1;
        @(negedge clock);
        req = 1'b1; wr = w; addr = a; len = l;
        @(posedge clock); #1;
        req = 1'b0;
        for (int c = 1; c <= 3 * n + 1; c++) begin
            if (c > 1) begin
                @(posedge clock); #1;
            end
            b  = (c - 1) / 3;
            p  = (c - 1) % 3;
            ea = a + 12'(b);
            if (c <= 3 * n) begin
                check("busy", busy, 1);
                check("done_low", done, 0);
                check("cs", csRAM, p == 1);
                check("we", weRAM, w);
                check("addr", address_ram, ea);
                check("wdata_req", wdata_req, w && p == 0);
                check("rvalid", rvalid, !w && p == 2);
                if (w && p != 0) check("bus_wr", data, beat_v[b]);
                if (!w && p == 1) check("bus_rd", data, mem[ea]);
                if (!w && p == 2) check("rdata", rdata, beat_v[b]);
                if (!w && p == 0 && b > 0) check("rdata_hold", rdata, beat_v[b-1]);
                if (w && p == 0) wdata = beat_v[b];
            end else begin
                check("busy_end", busy, 0);
                check("done", done, 1);
                check("cs_idle", csRAM, 0);
                check("we_idle", weRAM, 0);
            end
            if (c == inject_cyc) begin
                req = 1'b1; wr = 1'b1; addr = 12'h000; len = 4'd0;
            end else if (c == inject_cyc + 1) begin
                req = 1'b0; wr = w;
            end
        end
    endtask

    // Address must not move while cs is asserted.
    logic [11:0] prev_addr;
    logic        prev_cs;
    always @(posedge clock) begin
        #1;
        if (!reset && prev_cs && csRAM) check("cs_stretch", csRAM, 0);
        if (!reset && csRAM) check("addr_stable_cs", address_ram, prev_addr);
        prev_addr = address_ram;
        prev_cs   = csRAM;
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
        prev_addr = 12'h0; prev_cs = 1'b0;
        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 12'h0; len = 4'h0; wdata = 4'h0;
        #12;
        check("rst_cs", csRAM, 0);
        check("rst_we", weRAM, 0);
        check("rst_addr", address_ram, 12'h000);
        check("rst_rdata", rdata, 4'h0);
        check("rst_rvalid", rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wreq", wdata_req, 0);
        @(negedge clock); reset = 1'b0;

        // single write / read-back
        beat_v[0] = 4'hA;
        run_burst(1'b1, 12'h123, 4'd0, 0);
        check("mem_123", mem[12'h123], 4'hA);
        run_burst(1'b0, 12'h123, 4'd0, 0);

        // wrapping 4-beat write then read, with a request injected mid-read
        beat_v[0] = 4'h1; beat_v[1] = 4'h2; beat_v[2] = 4'h3; beat_v[3] = 4'h4;
        run_burst(1'b1, 12'hFFE, 4'd3, 0);
        check("mem_fff", mem[12'hFFF], 4'h2);
        check("mem_000", mem[12'h000], 4'h3);
        run_burst(1'b0, 12'hFFE, 4'd3, 5);
        beat_v[0] = 4'h3;
        run_burst(1'b0, 12'h000, 4'd0, 0);

        // req held high: next burst accepted on the done cycle
        @(negedge clock);
        req = 1'b1; wr = 1'b0; addr = 12'h123; len = 4'd0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            if (c == 3) check("held_rdata", rdata, 4'hA);
            if (c == 3) check("held_rvalid", rvalid, 1);
            if (c == 4) check("held_done", done, 1);
            if (c == 4) check("held_busy_lo", busy, 0);
        end
        @(posedge clock); #1;
        check("held_reaccept_busy", busy, 1);
        check("held_reaccept_done", done, 0);
        req = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            @(posedge clock); #1;
        end
        check("held_done2", done, 1);

        // reset during STROBE of beat 2 of a 4-beat write
        @(negedge clock);
        req = 1'b1; wr = 1'b1; addr = 12'h200; len = 4'd3;
        @(posedge clock); #1;
        req = 1'b0; wdata = 4'h5;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clock); #1;
            if (c == 4) wdata = 4'h6;
        end
        check("abort_strobe", csRAM, 1);
        reset = 1'b1;
        #1;
        check("abort_cs", csRAM, 0);
        check("abort_we", weRAM, 0);
        check("abort_busy", busy, 0);
        @(negedge clock); reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            check("abort_no_done", done, 0);
            check("abort_no_cs", csRAM, 0);
        end
        check("abort_mem_200", mem[12'h200], 4'h5);
        check("abort_mem_201", mem[12'h201], 4'h0);
        beat_v[0] = 4'h0;
        run_burst(1'b0, 12'h201, 4'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
